driver_readback: RTL and testbench

//  Reads back the 48-bit function-control (FC) word from each LED driver over its SOUT pin, one driver per dump.

---
 rtl/driver_readback.sv | 162 ++++++++++++++++
 tb/tb_driver_readback.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_readback.sv
// Boot-time FC readback: sweeps every LED driver, captures its SOUT dump and flags mismatches.
// Optional READBACK_MASK_EN adds conf_mask to ignore reserved/volatile FC bits in the compare.
module driver_readback #(
   parameter int NB_DRIVERS    = 30,
   parameter int WORD_WIDTH    = 48,
   parameter int SETTLE_CYCLES = 4,
   parameter int TIMEOUT       = 255
) (
   input  logic                  clk_lse,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] expected_conf,
`ifdef READBACK_MASK_EN
   input  logic [WORD_WIDTH-1:0] conf_mask,
`endif
   input  logic                  driver_sout,
   input  logic                  bit_valid,
   input  logic                  dump_end,
   output logic                  dump_req,
   output logic [4:0]            driver_sout_mux,
   output logic                  busy,
   output logic [WORD_WIDTH-1:0] readback_word,
   output logic                  readback_valid,
   output logic [NB_DRIVERS-1:0] mismatch,
   output logic                  timeout_flag,
   output logic                  done
);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_REQUEST, S_CAPTURE, S_CHECK, S_FINISH
   } state_t;

   localparam logic [5:0] LP_WW   = 6'(WORD_WIDTH);
   localparam logic [7:0] LP_TO   = 8'(TIMEOUT);
   localparam logic [4:0] LP_LAST = 5'(NB_DRIVERS - 1);
   localparam logic [3:0] LP_SET  = 4'(SETTLE_CYCLES - 1);

   state_t                r_state;
   logic [4:0]            r_index;
   logic [3:0]            r_settle;
   logic [5:0]            r_bit_cnt;
   logic [7:0]            r_idle_cnt;
   logic [WORD_WIDTH-1:0] r_shreg;
   logic                  r_dump_req;
   logic [4:0]            r_mux;
   logic                  r_busy;
   logic [WORD_WIDTH-1:0] r_rb_word;
   logic                  r_rb_valid;
   logic [NB_DRIVERS-1:0] r_mismatch;
   logic                  r_timeout;
   logic                  r_done;

   logic [NB_DRIVERS-1:0] w_sel;
   logic [WORD_WIDTH-1:0] w_diff;
   logic                  w_bad;

   assign w_sel = NB_DRIVERS'(1) << r_index;
`ifdef READBACK_MASK_EN
   assign w_diff = (r_shreg ^ expected_conf) & conf_mask;
`else
   assign w_diff = r_shreg ^ expected_conf;
`endif
   assign w_bad = (r_bit_cnt != LP_WW) | (|w_diff);

   always_ff @(posedge clk_lse or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_IDLE;
         r_index    <= '0;
         r_settle   <= '0;
         r_bit_cnt  <= '0;
         r_idle_cnt <= '0;
         r_shreg    <= '0;
         r_dump_req <= 1'b0;
         r_mux      <= '0;
         r_busy     <= 1'b0;
         r_rb_word  <= '0;
         r_rb_valid <= 1'b0;
         r_mismatch <= '0;
         r_timeout  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_dump_req <= 1'b0;
         r_rb_valid <= 1'b0;
         r_done     <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mismatch <= '0;
                  r_timeout  <= 1'b0;
                  r_index    <= '0;
                  r_mux      <= '0;
                  r_settle   <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (r_settle == LP_SET) begin
                  r_dump_req <= 1'b1;
                  r_state    <= S_REQUEST;
               end else begin
                  r_settle <= r_settle + 4'd1;
               end
            end
            S_REQUEST: begin
               r_bit_cnt  <= '0;
               r_idle_cnt <= '0;
               r_state    <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (bit_valid) begin
                  // Extra bits past the word are dropped, shreg stays frozen.
                  if (r_bit_cnt != LP_WW) begin
                     r_shreg   <= {r_shreg[WORD_WIDTH-2:0], driver_sout};
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
                  r_idle_cnt <= '0;
                  if (dump_end) r_state <= S_CHECK;
               end else if (dump_end) begin
                  r_state <= S_CHECK;
               end else if (r_idle_cnt + 8'd1 == LP_TO) begin
                  r_timeout  <= 1'b1;
                  r_mismatch <= r_mismatch | w_sel;
                  r_state    <= S_CHECK;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 8'd1;
               end
            end
            S_CHECK: begin
               r_rb_word  <= r_shreg;
               r_rb_valid <= 1'b1;
               r_mismatch <= r_mismatch | (w_sel & {NB_DRIVERS{w_bad}});
               if (r_index == LP_LAST) begin
                  r_state <= S_FINISH;
               end else begin
                  r_index  <= r_index + 5'd1;
                  r_mux    <= r_index + 5'd1;
                  r_settle <= '0;
                  r_state  <= S_SELECT;
               end
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_mux   <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dump_req        = r_dump_req;
   assign driver_sout_mux = r_mux;
   assign busy            = r_busy;
   assign readback_word   = r_rb_word;
   assign readback_valid  = r_rb_valid;
   assign mismatch        = r_mismatch;
   assign timeout_flag    = r_timeout;
   assign done            = r_done;

endmodule

// File: tb/tb_driver_readback.sv
// Randomized bench for driver_readback: emulates the dump controller and
// predicts readback words and mismatch bitmap from a behavioural model.
module tb_driver_readback;
   localparam int NB = 30;

   logic        clk_lse = 1'b0;
   logic        nrst;
   logic        start;
   logic [47:0] expected_conf;
`ifdef READBACK_MASK_EN
   logic [47:0] conf_mask;
`endif
   logic        driver_sout;
   logic        bit_valid;
   logic        dump_end;
   logic        dump_req;
   logic [4:0]  driver_sout_mux;
   logic        busy;
   logic [47:0] readback_word;
   logic        readback_valid;
   logic [29:0] mismatch;
   logic        timeout_flag;
   logic        done;

   driver_readback dut (
      .clk_lse(clk_lse), .nrst(nrst), .start(start),
      .expected_conf(expected_conf),
`ifdef READBACK_MASK_EN
      .conf_mask(conf_mask),
`endif
      .driver_sout(driver_sout), .bit_valid(bit_valid),
      .dump_end(dump_end), .dump_req(dump_req),
      .driver_sout_mux(driver_sout_mux), .busy(busy),
      .readback_word(readback_word), .readback_valid(readback_valid),
      .mismatch(mismatch), .timeout_flag(timeout_flag), .done(done)
   );

   always #5 clk_lse = ~clk_lse;

   int n_cmp = 0;
   int n_err = 0;
   int rv_cnt = 0;
   int done_cnt = 0;

   always @(negedge clk_lse) begin
      if (readback_valid === 1'b1) rv_cnt++;
      if (done === 1'b1) done_cnt++;
   end

   // per-driver dump description
   int          nb [NB];
   logic [63:0] data [NB];
   bit          to [NB];
   bit          same [NB];
   // reference model state
   logic [47:0] m_shreg;
   logic [47:0] m_mask;
   logic [29:0] m_mis;
   bit          m_to;

   task automatic set_default(input logic [47:0] e);
      expected_conf = e;
      for (int d = 0; d < NB; d++) begin
         nb[d]   = 48;
         data[d] = {16'h0, e};
         to[d]   = 1'b0;
         same[d] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drive_dump(input int d);
      int n;
      n = nb[d];
      if (!to[d]) begin
         for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
               @(negedge clk_lse);
               bit_valid = 1'b0;
               dump_end  = 1'b0;
            end
            @(negedge clk_lse);
            bit_valid   = 1'b1;
            driver_sout = data[d][n-1-i];
            dump_end    = (i == n - 1) && same[d];
         end
         @(negedge clk_lse);
         bit_valid = 1'b0;
         dump_end  = !(same[d] && n > 0);
         @(negedge clk_lse);
         dump_end  = 1'b0;
      end
   endtask

   task automatic model_dump(input int d);
      logic [47:0] w;
      int c;
      bit bad;
      w = m_shreg;
      c = 0;
      if (!to[d]) begin
         for (int i = 0; i < nb[d]; i++) begin
            if (c < 48) begin
               w = {w[46:0], data[d][nb[d]-1-i]};
               c++;
            end
         end
      end
      m_shreg = w;
      bad = to[d] || (c != 48) || (((w ^ expected_conf) & m_mask) != 48'h0);
      if (bad) m_mis[d] = 1'b1;
      if (to[d]) m_to = 1'b1;
   endtask

   task automatic sweep(input int restart_at, input int abort_at);
      int rv0;
      int dn0;
      int k;
      m_mis = '0;
      m_to  = 1'b0;
      @(negedge clk_lse);
      start = 1'b1;
      @(negedge clk_lse);
      start = 1'b0;
      rv0 = rv_cnt;
      dn0 = done_cnt;
      for (int d = 0; d < NB; d++) begin
         k = 0;
         while (dump_req !== 1'b1 && k < 40) begin
            @(negedge clk_lse);
            k++;
         end
         n_cmp++;
         if (dump_req !== 1'b1) begin
            n_err++;
            $display("FAIL dump_req_wait drv %0d: got %b required 1", d, dump_req);
            return;
         end
         n_cmp++;
         if (driver_sout_mux !== 5'(d) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mux_busy drv %0d: got mux %0d busy %b required mux %0d busy 1",
                     d, driver_sout_mux, busy, d);
         end
         if (d == abort_at) begin
            @(negedge clk_lse);
            nrst = 1'b0;
            #1;
            n_cmp++;
            if ({dump_req, driver_sout_mux, busy, readback_word, readback_valid,
                 mismatch, timeout_flag, done} !== '0) begin
               n_err++;
               $display("FAIL reset_mid: got busy %b mux %0d mis %h word %h required all 0",
                        busy, driver_sout_mux, mismatch, readback_word);
            end
            m_shreg = '0;
            repeat (3) @(negedge clk_lse);
            nrst = 1'b1;
            repeat (40) @(negedge clk_lse);
            n_cmp++;
            if (done_cnt != dn0 || busy !== 1'b0 || dump_req !== 1'b0) begin
               n_err++;
               $display("FAIL after_reset: got dones %0d busy %b req %b required 0 0 0",
                        done_cnt - dn0, busy, dump_req);
            end
            return;
         end
         if (d == restart_at) begin
            @(negedge clk_lse);
            start = 1'b1;
            @(negedge clk_lse);
            start = 1'b0;
         end
         drive_dump(d);
         model_dump(d);
         k = 0;
         while (readback_valid !== 1'b1 && k < 400) begin
            @(negedge clk_lse);
            k++;
         end
         n_cmp++;
         if (readback_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rv_wait drv %0d: got %b required 1", d, readback_valid);
         end else begin
            n_cmp++;
            if (readback_word !== m_shreg) begin
               n_err++;
               $display("FAIL word drv %0d: got %h required %h", d, readback_word, m_shreg);
            end
         end
         @(negedge clk_lse);
      end
      k = 0;
      while (done !== 1'b1 && k < 20) begin
         @(negedge clk_lse);
         k++;
      end
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL done_wait: got done %b busy %b required 1 0", done, busy);
      end
      @(negedge clk_lse);
      n_cmp++;
      if (mismatch !== m_mis || timeout_flag !== m_to) begin
         n_err++;
         $display("FAIL bitmap: got %h to %b required %h to %b",
                  mismatch, timeout_flag, m_mis, m_to);
      end
      n_cmp++;
      if (rv_cnt - rv0 != NB || done_cnt - dn0 != 1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL pulses: got rv %0d done %0d required rv %0d done 1",
                  rv_cnt - rv0, done_cnt - dn0, NB);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      start = 1'b0;
      driver_sout = 1'b0;
      bit_valid = 1'b0;
      dump_end = 1'b0;
      expected_conf = '0;
      m_mask = '1;
`ifdef READBACK_MASK_EN
      conf_mask = '1;
`endif
      m_shreg = '0;
      repeat (3) @(negedge clk_lse);
      n_cmp++;
      if ({dump_req, driver_sout_mux, busy, readback_word, readback_valid,
           mismatch, timeout_flag, done} !== '0) begin
         n_err++;
         $display("FAIL reset: got busy %b mux %0d mis %h word %h required all 0",
                  busy, driver_sout_mux, mismatch, readback_word);
      end
      nrst = 1'b1;
      // stray controller strobes while idle must be ignored
      bit_valid = 1'b1;
      dump_end = 1'b1;
      repeat (3) @(negedge clk_lse);
      bit_valid = 1'b0;
      dump_end = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || readback_valid !== 1'b0 || dump_req !== 1'b0) begin
         n_err++;
         $display("FAIL idle_ignore: got busy %b rv %b req %b required 0 0 0",
                  busy, readback_valid, dump_req);
      end
   endtask

   task automatic test_all_match();
      set_default(48'hA5A5_1234_5678);
      sweep(-1, -1);
      n_cmp++;
      if (mismatch !== 30'h0) begin
         n_err++;
         $display("FAIL all_match: got %h required 0", mismatch);
      end
   endtask

   task automatic test_flip7();
      set_default(48'hA5A5_1234_5678);
      data[7] = {16'h0, 48'hA5A5_1234_5679};
      sweep(-1, -1);
      n_cmp++;
      if (mismatch !== 30'h0000_0080) begin
         n_err++;
         $display("FAIL flip7: got %h required 00000080", mismatch);
      end
   endtask

   task automatic test_short_long();
      logic [47:0] e;
      e = {16'($urandom), 32'($urandom)};
      set_default(e);
      nb[0]   = 40;
      data[0] = {24'h0, e[47:8]};
      nb[1]   = 52;
      data[1] = {12'h0, e, 4'($urandom)};
      sweep(-1, -1);
   endtask

   task automatic test_timeout();
      set_default(48'h0123_4567_89AB);
      to[29] = 1'b1;
      sweep(-1, -1);
      n_cmp++;
      if (timeout_flag !== 1'b1 || mismatch !== 30'h2000_0000) begin
         n_err++;
         $display("FAIL timeout29: got to %b mis %h required 1 20000000",
                  timeout_flag, mismatch);
      end
   endtask

   task automatic test_start_busy();
      set_default({16'($urandom), 32'($urandom)});
      sweep(3, -1);
   endtask

   task automatic test_reset_mid();
      set_default({16'($urandom), 32'($urandom)});
      sweep(-1, 10);
   endtask

   task automatic test_random();
      for (int s = 0; s < 3; s++) begin
         logic [47:0] e;
         e = {16'($urandom), 32'($urandom)};
         set_default(e);
         for (int d = 0; d < NB; d++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
               data[d][$urandom_range(0, 47)] ^= 1'b1;
            end else if (r == 1) begin
               nb[d]   = $urandom_range(0, 47);
               data[d] = {$urandom, $urandom};
            end else if (r == 2) begin
               int x;
               x = $urandom_range(1, 12);
               nb[d]   = 48 + x;
               data[d] = ({16'h0, e} << x) | (64'($urandom) & ((64'd1 << x) - 64'd1));
            end
         end
         sweep(-1, -1);
      end
   endtask

`ifdef READBACK_MASK_EN
   task automatic test_mask();
      logic [47:0] e;
      e = 48'hA5A5_1234_5678;
      set_default(e);
      data[2] = {16'h0, e ^ 48'h5};
      conf_mask = 48'hFFFF_FFFF_FFF0;
      m_mask = conf_mask;
      sweep(-1, -1);
      n_cmp++;
      if (mismatch !== 30'h0) begin
         n_err++;
         $display("FAIL mask_on: got %h required 0", mismatch);
      end
      conf_mask = '1;
      m_mask = '1;
      sweep(-1, -1);
      n_cmp++;
      if (mismatch !== 30'h4) begin
         n_err++;
         $display("FAIL mask_full: got %h required 4", mismatch);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_all_match();
      test_flip7();
      test_short_long();
      test_timeout();
      test_start_busy();
      test_reset_mid();
      test_random();
`ifdef READBACK_MASK_EN
      test_mask();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
